gray_code_counter: RTL and testbench

GRAY_CODE_COUNTER -- requirements
Module: gray_code_counter

---
 rtl/gray_pkg.sv | 22 ++
 rtl/gray_code_counter.sv | 67 ++++++
 tb/tb_gray_code_counter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - Width-agnostic binary/Gray conversion helpers shared by counter and converter.
package gray_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  // Callers zero-extend narrower values; zero upper bits leave the low bits exact.
  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_code_counter.sv
// rtl/gray_code_counter.sv - Up/down Gray counter with load, valid/ready output and wrap pulse.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_value,
  output logic [N-1:0] gray_value,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         wrap
);

  logic [N-1:0] r_bin;
  logic [N-1:0] r_gray;
  logic         r_valid;
  logic         r_wrap;

  logic         w_step;
  logic         w_wrap_step;
  logic [N-1:0] w_next_bin;
  logic [N-1:0] w_next_gray;
  logic [N-1:0] w_load_bin;
  logic [N-1:0] w_load_gray;

  // A held value blocks stepping until it has been accepted downstream.
  assign w_step      = en && !load && (!r_valid || out_ready);
  assign w_next_bin  = up_dn ? (r_bin + N'(1)) : (r_bin - N'(1));
  assign w_wrap_step = up_dn ? (&r_bin) : ~(|r_bin);
  assign w_next_gray = N'(bin2gray(gray_word_t'(w_next_bin)));
  assign w_load_bin  = N'(gray2bin(gray_word_t'(load_value)));
  assign w_load_gray = N'(bin2gray(gray_word_t'(w_load_bin)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_bin   <= w_load_bin;
      r_gray  <= w_load_gray;
      r_valid <= 1'b1;
      r_wrap  <= 1'b0;
    end else if (w_step) begin
      r_bin   <= w_next_bin;
      r_gray  <= w_next_gray;
      r_valid <= 1'b1;
      r_wrap  <= w_wrap_step;
    end else begin
      r_wrap <= 1'b0;
      if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign gray_value = r_gray;
  assign out_valid  = r_valid;
  assign wrap       = r_wrap;

endmodule

// File: tb/tb_gray_code_counter.sv
// tb/tb_gray_code_counter.sv - Scoreboard bench for gray_code_counter at N=4.
module tb_gray_code_counter;

  typedef struct packed {
    logic [3:0] g;
    logic       v;
    logic       w;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] gray_value;
  logic       out_valid;
  logic       out_ready;
  logic       wrap;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  gray_code_counter #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up_dn     (up_dn),
    .load      (load),
    .load_value(load_value),
    .gray_value(gray_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [3:0] g, input logic v, input logic w);
    exp_t e;
    e.g = g;
    e.v = v;
    e.w = w;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en   = 1'b0;
    load = 1'b0;
    cyc();
    rst  = 1'b0;
  endtask

  function automatic logic [3:0] m_g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; load = 1'b1; load_value = 4'hF; en = 1'b1; up_dn = 1'b1; out_ready = 1'b1;
    push(4'h0, 1'b0, 1'b0);
    cyc();
    e = sb.pop_front();
    n_tests++;
    if ({gray_value, out_valid, wrap} !== e) begin
      n_fail++;
      $display("FAIL reset: got g=%h v=%b w=%b expected g=%h v=%b w=%b", gray_value, out_valid, wrap, e.g, e.v, e.w);
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_count_up();
    logic [3:0] tbl [16];
    exp_t e;
    tbl = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
            4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    do_reset();
    en = 1'b1; up_dn = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push(tbl[i], 1'b1, (i == 15));
      cyc();
      e = sb.pop_front();
      n_tests++;
      if ({gray_value, out_valid, wrap} !== e) begin
        n_fail++;
        $display("FAIL count_up[%0d]: got g=%h v=%b w=%b expected g=%h v=%b w=%b", i, gray_value, out_valid, wrap, e.g, e.v, e.w);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_count_down();
    exp_t e;
    do_reset();
    en = 1'b1; up_dn = 1'b0; out_ready = 1'b1;
    push(4'h8, 1'b1, 1'b1);
    push(4'h9, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      e = sb.pop_front();
      n_tests++;
      if ({gray_value, out_valid, wrap} !== e) begin
        n_fail++;
        $display("FAIL count_down[%0d]: got g=%h v=%b w=%b expected g=%h v=%b w=%b", i, gray_value, out_valid, wrap, e.g, e.v, e.w);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load();
    logic       ld  [7];
    logic       ena [7];
    logic       dir [7];
    logic       rdy [7];
    logic [3:0] lv  [7];
    exp_t e;
    // load with en, up step, load max, wrap step, load zero, load into stall, stall hold
    ld  = '{1, 0, 1, 0, 1, 1, 0};
    ena = '{1, 1, 1, 1, 1, 0, 1};
    dir = '{0, 1, 0, 1, 0, 1, 1};
    rdy = '{1, 1, 1, 1, 1, 0, 0};
    lv  = '{4'h6, 4'h0, 4'h8, 4'h0, 4'h0, 4'h5, 4'h0};
    push(4'h6, 1, 0); push(4'h7, 1, 0); push(4'h8, 1, 0); push(4'h0, 1, 1);
    push(4'h0, 1, 0); push(4'h5, 1, 0); push(4'h5, 1, 0);
    for (int i = 0; i < 7; i++) begin
      load = ld[i]; en = ena[i]; up_dn = dir[i]; out_ready = rdy[i]; load_value = lv[i];
      cyc();
      e = sb.pop_front();
      n_tests++;
      if ({gray_value, out_valid, wrap} !== e) begin
        n_fail++;
        $display("FAIL load[%0d]: got g=%h v=%b w=%b expected g=%h v=%b w=%b", i, gray_value, out_valid, wrap, e.g, e.v, e.w);
      end
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t e;
    do_reset();
    en = 1'b1; up_dn = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      out_ready = (i < 2 || i == 7) ? 1'b1 : 1'b0;
      en        = (i < 8) ? 1'b1 : 1'b0;
      if (i == 8) out_ready = 1'b1;
      case (i)
        0:       push(4'h1, 1, 0);
        7:       push(4'h2, 1, 0);
        8:       push(4'h2, 0, 0);
        default: push(4'h3, 1, 0);
      endcase
      cyc();
      e = sb.pop_front();
      n_tests++;
      if ({gray_value, out_valid, wrap} !== e) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: got g=%h v=%b w=%b expected g=%h v=%b w=%b", i, gray_value, out_valid, wrap, e.g, e.v, e.w);
      end
    end
    // Drained and idle: a step must proceed even with out_ready low.
    en = 1'b1; out_ready = 1'b0;
    push(4'h6, 1, 0);
    cyc();
    e = sb.pop_front();
    n_tests++;
    if ({gray_value, out_valid, wrap} !== e) begin
      n_fail++;
      $display("FAIL step_when_idle: got g=%h v=%b w=%b expected g=%h v=%b w=%b", gray_value, out_valid, wrap, e.g, e.v, e.w);
    end
    en = 1'b0;
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    en = 1'b0; out_ready = 1'b0; load = 1'b1; load_value = 4'hF;
    push(4'hF, 1, 0);
    cyc();
    rst = 1'b1; load = 1'b1; load_value = 4'h3; en = 1'b1;
    push(4'h0, 0, 0);
    cyc();
    rst = 1'b0; load = 1'b0; en = 1'b1; up_dn = 1'b0; out_ready = 1'b1;
    push(4'h8, 1, 1);
    cyc();
    rst = 1'b1;
    push(4'h0, 0, 0);
    cyc();
    rst = 1'b0; up_dn = 1'b1;
    push(4'h1, 1, 0);
    cyc();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = sb.pop_front();
      n_tests++;
      if (i == 0) begin
        if ({gray_value, out_valid, wrap} !== {4'h1, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL reset_midstream_final: got g=%h v=%b w=%b expected g=1 v=1 w=0", gray_value, out_valid, wrap);
        end
      end else if (e.v === 1'bx) begin
        n_fail++;
        $display("FAIL reset_midstream_sb: got x expected known");
      end
    end
  endtask

  task automatic test_reset_rst_load();
    exp_t e;
    logic       r_l [4];
    logic [3:0] lv  [4];
    r_l = '{0, 1, 0, 1};
    lv  = '{4'hF, 4'h3, 4'h0, 4'h0};
    push(4'hF, 1, 0); push(4'h0, 0, 0); push(4'h8, 1, 1); push(4'h0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      rst = r_l[i]; load = (i < 2); load_value = lv[i];
      en = (i != 0); up_dn = 1'b0; out_ready = (i >= 2);
      cyc();
      e = sb.pop_front();
      n_tests++;
      if ({gray_value, out_valid, wrap} !== e) begin
        n_fail++;
        $display("FAIL rst_load[%0d]: got g=%h v=%b w=%b expected g=%h v=%b w=%b", i, gray_value, out_valid, wrap, e.g, e.v, e.w);
      end
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] mb = 4'h0;
    logic       mv = 1'b0;
    logic       mw;
    logic       step;
    logic [3:0] prev_g = 4'h0;
    exp_t e;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      en         = ($urandom_range(3) != 0);
      up_dn      = $urandom_range(1);
      out_ready  = $urandom_range(1);
      load       = ($urandom_range(15) == 0);
      load_value = 4'($urandom_range(15));
      step = en && !load && (!mv || out_ready);
      mw   = 1'b0;
      if (load) begin
        mb = m_g2b(load_value);
        mv = 1'b1;
      end else if (step) begin
        mw = up_dn ? (mb == 4'hF) : (mb == 4'h0);
        mb = up_dn ? mb + 4'd1 : mb - 4'd1;
        mv = 1'b1;
      end else if (mv && out_ready) begin
        mv = 1'b0;
      end
      push(mb ^ (mb >> 1), mv, mw);
      cyc();
      e = sb.pop_front();
      n_tests++;
      if ({gray_value, out_valid, wrap} !== e) begin
        n_fail++;
        $display("FAIL random[%0d]: got g=%h v=%b w=%b expected g=%h v=%b w=%b", i, gray_value, out_valid, wrap, e.g, e.v, e.w);
      end
      if (step) begin
        n_tests++;
        if ($countones(gray_value ^ prev_g) !== 1) begin
          n_fail++;
          $display("FAIL one_bit_step[%0d]: got %h after %h expected one-bit change", i, gray_value, prev_g);
        end
      end
      prev_g = e.g;
    end
    en = 1'b0; load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_value = 4'h0; out_ready = 1'b0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_backpressure();
    test_reset_rst_load();
    do_reset();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
